// File: rtl/sram_1r1w_ctrl_pkg.sv
// Shared types for the 1R1W SRAM controller: FSM state encoding and a
// pointer-width helper used by the controller and its arbiter.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_ctrl_state_t;

  // Round-robin pointer width; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_1r1w_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping around. The pointer itself lives in the caller.
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic          w_found;
  logic          w_hit;
  logic [PW-1:0] w_idx;
  int            w_sum;

  // Rotating priority scan starting at ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_hit     = 1'b0;
    w_idx     = '0;
    w_sum     = 0;
    for (int off = 0; off < N; off++) begin
      w_sum            = int'(ptr) + off;
      w_idx            = (w_sum >= N) ? PW'(w_sum - N) : PW'(w_sum);
      w_hit            = !w_found && req[w_idx];
      grant[w_idx]     = grant[w_idx] | w_hit;
      grant_idx        = w_hit ? w_idx : grant_idx;
      w_found          = w_found | w_hit;
    end
  end

endmodule

// File: rtl/sram_1r1w_ctrl.sv
// Sequencer for one 1R1W SRAM wrapper: clears the array after reset/flush,
// round-robins the write port, and returns reads after two cycles with
// write-first forwarding on same-address collisions.
module sram_1r1w_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 68,
  parameter int               DEPTH      = 256,
  parameter int               ADDR_WIDTH = $clog2(DEPTH),
  parameter int               WR_PORTS   = 2,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  output logic                           init_done,
  input  logic [WR_PORTS-1:0]            wr_req,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*WIDTH-1:0]      wr_data,
  output logic [WR_PORTS-1:0]            wr_grant,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_valid,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           ram_wen,
  output logic [ADDR_WIDTH-1:0]          ram_waddr,
  output logic [WIDTH-1:0]               ram_wdata,
  output logic                           ram_ren,
  output logic [ADDR_WIDTH-1:0]          ram_raddr,
  input  logic [WIDTH-1:0]               ram_rdata
);

  localparam int PW = ptr_width(WR_PORTS);

  sram_ctrl_state_t        r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [PW-1:0]           r_ptr;
  logic                    r_init_done;
  logic                    r_s1_valid, r_s1_fwd, r_s2_valid, r_s2_fwd;
  logic [WIDTH-1:0]        r_s1_data, r_s2_data;

  logic [WR_PORTS-1:0]     w_grant;
  logic [PW-1:0]           w_grant_idx;
  logic                    w_run;
  logic                    w_fwd;
  logic [ADDR_WIDTH-1:0]   w_addr_arr [WR_PORTS];
  logic [WIDTH-1:0]        w_data_arr [WR_PORTS];

  for (genvar g = 0; g < WR_PORTS; g++) begin : g_unpack
    assign w_addr_arr[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[g] = wr_data[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(WR_PORTS), .PW(PW)) u_arb (
    .req       (wr_req),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_run     = (r_state == RUN);
  assign init_done = r_init_done;
  assign wr_grant  = w_run ? w_grant : '0;
  assign ram_ren   = w_run & rd_en;
  assign ram_raddr = rd_addr;
  assign w_fwd     = ram_ren & ram_wen & (rd_addr == ram_waddr);
  assign rd_valid  = r_s2_valid;
  assign rd_data   = !r_s2_valid ? '0 : (r_s2_fwd ? r_s2_data : ram_rdata);

  // Write port mux: init sweep owns the port until the array is cleared
  always_comb begin
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (!w_run) begin
      ram_wen   = 1'b1;
      ram_waddr = r_cnt;
      ram_wdata = INIT_VALUE;
    end else begin
      ram_wen   = |wr_req;
      ram_waddr = w_addr_arr[w_grant_idx];
      ram_wdata = w_data_arr[w_grant_idx];
    end
  end

  // Init/run FSM with clear counter and registered init_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (flush) begin
            r_cnt <= '0;
          end else if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state     <= INIT;
          r_cnt       <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer advances past the port just granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_run && (|wr_req)) begin
      r_ptr <= (w_grant_idx == PW'(WR_PORTS - 1)) ? '0 : w_grant_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Two-stage read pipeline tracking validity and forwarded write data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_fwd   <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_fwd   <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s1_valid <= ram_ren;
      r_s1_fwd   <= w_fwd;
      r_s1_data  <= ram_wdata;
      r_s2_valid <= r_s1_valid;
      r_s2_fwd   <= r_s1_fwd;
      r_s2_data  <= r_s1_data;
    end
  end

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Scoreboard bench for sram_1r1w_ctrl with a 2-cycle-latency SRAM model.
module tb_sram_1r1w_ctrl;
  localparam int W  = 68;
  localparam int D  = 256;
  localparam int AW = 8;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst, flush, init_done, rd_en, rd_valid;
  logic ram_wen, ram_ren;
  logic [NP-1:0]    wr_req, wr_grant;
  logic [NP*AW-1:0] wr_addr;
  logic [NP*W-1:0]  wr_data;
  logic [AW-1:0]    rd_addr, ram_waddr, ram_raddr;
  logic [W-1:0]     rd_data, ram_wdata, ram_rdata;

  logic [W-1:0] mem [D];
  logic [W-1:0] m_rd1, m_rd2;
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  sram_1r1w_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .WR_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: read samples old contents, data appears two edges later
  initial begin
    for (int i = 0; i < D; i++) mem[i] = {4'h5, 32'hDEAD_BEEF, 32'(i)};
    m_rd1 = '0;
    m_rd2 = '0;
  end
  always @(posedge clk) begin
    if (ram_ren) m_rd1 <= mem[ram_raddr];
    m_rd2 <= m_rd1;
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end
  assign ram_rdata = m_rd2;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every rd_valid beat pops one expected value
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no read", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; rd_en = 1'b0; rd_addr = '0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_init_done", W'(init_done), '0);
    check("rst_rd_valid", W'(rd_valid), '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_grant", W'(wr_grant), '0);
    tick();
    rst = 1'b0;
    // Requests during init must be ignored
    rd_en = 1'b1; rd_addr = 8'h10; wr_req = 2'b11;
    for (int c = 0; c < 255; c++) begin
      @(negedge clk);
      if (c == 0 || c == 128 || c == 254) begin
        check("init_addr", W'(ram_waddr), W'(c));
        check("init_grant", W'(wr_grant), '0);
        check("init_ren", W'(ram_ren), '0);
      end
      tick();
    end
    rd_en = 1'b0; wr_req = 2'b00;
    @(negedge clk);
    check("init_done_c255", W'(init_done), '0);
    check("init_addr_last", W'(ram_waddr), W'(255));
    tick();
    @(negedge clk);
    check("init_done_c256", W'(init_done), W'(1));

    rd(8'h7F, '0);
    tick();
    rd_en = 1'b0;

    // Round robin with both ports requesting
    wr_addr = {8'd9, 8'd8};
    wr_data = {68'h222, 68'h111};
    wr_req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant", W'(wr_grant), (i % 2 == 0) ? W'(1) : W'(2));
      tick();
    end
    wr_req  = 2'b10;
    wr_data = {68'h333, 68'h111};
    @(negedge clk);
    check("rr_single", W'(wr_grant), W'(2));
    tick();
    wr_req = 2'b00;

    // Same-cycle read/write collision
    wr_req  = 2'b01;
    wr_addr = {8'd0, 8'd5};
    wr_data = {68'h0, 68'hABC};
    rd(8'd5, 68'hABC);
    @(negedge clk);
    check("coll_grant", W'(wr_grant), W'(1));
    tick();
    wr_req = 2'b00;
    rd(8'd5, 68'hABC);
    tick();
    rd(8'd8, 68'h111);
    tick();
    rd(8'd9, 68'h333);
    tick();
    rd_en = 1'b0;

    // Full-width writes then back-to-back reads
    wr_req = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      wr_addr = {8'(i), 8'd0};
      wr_data = {4'hF, 60'h0, 4'(i), 68'h0};
      tick();
    end
    wr_req = 2'b00;
    rd(8'd1, {4'hF, 60'h0, 4'h1});
    tick();
    rd(8'd2, {4'hF, 60'h0, 4'h2});
    tick();
    rd(8'd3, {4'hF, 60'h0, 4'h3});
    tick();
    rd_en = 1'b0;
    repeat (3) tick();

    // Flush in RUN, then a second flush mid-init
    flush = 1'b1; wr_req = 2'b11;
    @(negedge clk);
    check("flush_f_done", W'(init_done), W'(1));
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_f1_done", W'(init_done), '0);
    check("flush_grant", W'(wr_grant), '0);
    repeat (10) tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_mid_addr", W'(ram_waddr), W'(10));
    tick();
    flush = 1'b0; wr_req = 2'b00;
    @(negedge clk);
    check("flush_restart", W'(ram_waddr), '0);
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
    check("reinit_len", W'(n), W'(256));
    rd(8'd5, '0);
    tick();
    rd(8'd9, '0);
    tick();
    rd(8'd1, '0);
    tick();
    rd_en = 1'b0;
    repeat (3) tick();

    // Async reset aborts reads in flight
    rd_en = 1'b1; rd_addr = 8'd2;
    tick();
    rd_addr = 8'd3;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("arst_valid_t1", W'(rd_valid), '0);
    tick();
    @(negedge clk);
    check("arst_valid_t2", W'(rd_valid), '0);
    check("arst_data_t2", rd_data, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("arst_done", W'(init_done), '0);
    check("arst_addr0", W'(ram_waddr), '0);
    check("arst_wen", W'(ram_wen), W'(1));
    tick();
    @(negedge clk);
    check("arst_addr1", W'(ram_waddr), W'(1));
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
    check("arst_reinit", W'(init_done), W'(1));
    repeat (3) tick();
    check("queue_empty", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
